// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, debouncer, press/release/long-press pulse generator
// Each channel is independent; raw pins are active-low and asynchronous to clk.
module key_debounce #(
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_CYCLES = 120900,
  parameter int LONG_CYCLES     = 12090000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] sw_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_key
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_long;
  logic [DW-1:0]     r_db_cnt   [N_KEYS];
  logic [HW-1:0]     r_hold_cnt [N_KEYS];

  logic [N_KEYS-1:0] w_level_nxt;
  logic [N_KEYS-1:0] w_long_nxt;
  logic [DW-1:0]     w_db_nxt   [N_KEYS];
  logic [HW-1:0]     w_hold_nxt [N_KEYS];

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      w_level_nxt[i] = r_level[i];
      w_db_nxt[i]    = '0;
      w_hold_nxt[i]  = r_hold_cnt[i];
      w_long_nxt[i]  = 1'b0;

      // Any agreement between sampled and debounced state restarts the window.
      if (r_sync2[i] != r_level[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_level_nxt[i] = r_sync2[i];
        end else begin
          w_db_nxt[i] = r_db_cnt[i] + DW'(1);
        end
      end

      // Hold count stays 0 in the press cycle and counts from the next one on.
      if (!w_level_nxt[i]) begin
        w_hold_nxt[i] = '0;
      end else if (r_level[i] && (r_hold_cnt[i] != HOLD_MAX)) begin
        w_hold_nxt[i] = r_hold_cnt[i] + HW'(1);
      end

      w_long_nxt[i] = r_level[i] & w_level_nxt[i] & (r_hold_cnt[i] == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_db_cnt[i]   <= '0;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= ~sw_n;
      r_sync2   <= r_sync1;
      r_level   <= w_level_nxt;
      r_press   <= w_level_nxt & ~r_level;
      r_release <= ~w_level_nxt & r_level;
      r_long    <= w_long_nxt;
      for (int i = 0; i < N_KEYS; i++) begin
        r_db_cnt[i]   <= w_db_nxt[i];
        r_hold_cnt[i] <= w_hold_nxt[i];
      end
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign any_key     = |r_level;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed vector table plus multi-cycle sequences for key_debounce
module tb_key_debounce;

  localparam int NK = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] sw_n;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic          any_key;

  key_debounce #(.N_KEYS(NK), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .sw_n(sw_n),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .any_key(any_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NK-1:0] sw_n;
    int            ncyc;
    logic [NK-1:0] lvl, prs, rel, lng;
    logic          anyk;
  } vec_t;

  vec_t tbl [12];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int press_cnt [NK], release_cnt [NK], long_cnt [NK];
  int press_cyc [NK], release_cyc [NK], long_cyc [NK];
  logic [NK-1:0] level_seen;
  logic both_seen, any_bad;
  int c0, r0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0;
      press_cyc[i] = -1; release_cyc[i] = -1; long_cyc[i] = -1;
    end
    level_seen = '0;
  endtask

  // One rising edge, then sample outputs 1 time unit later and log pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin press_cnt[i]++;   press_cyc[i]   = cyc; end
      if (key_release[i]) begin release_cnt[i]++; release_cyc[i] = cyc; end
      if (key_long[i])    begin long_cnt[i]++;    long_cyc[i]    = cyc; end
    end
    level_seen |= key_level;
    if ((key_press & key_release) != '0) both_seen = 1'b1;
    if (any_key != (key_level != '0)) any_bad = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    sw_n = '1;
    both_seen = 1'b0;
    any_bad = 1'b0;
    clear_cnt();

    //          rst   sw_n   n   level  press  release long  any
    tbl[0]  = '{1'b1, 6'h3F, 2,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[1]  = '{1'b0, 6'h3F, 3,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[2]  = '{1'b0, 6'h3E, 9,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[3]  = '{1'b0, 6'h3E, 1,  6'h01, 6'h01, 6'h00, 6'h00, 1'b1};
    tbl[4]  = '{1'b0, 6'h3E, 1,  6'h01, 6'h00, 6'h00, 6'h00, 1'b1};
    tbl[5]  = '{1'b0, 6'h3F, 9,  6'h01, 6'h00, 6'h00, 6'h00, 1'b1};
    tbl[6]  = '{1'b0, 6'h3F, 1,  6'h00, 6'h00, 6'h01, 6'h00, 1'b0};
    tbl[7]  = '{1'b0, 6'h3F, 1,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[8]  = '{1'b0, 6'h0F, 9,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};
    tbl[9]  = '{1'b0, 6'h0F, 1,  6'h30, 6'h30, 6'h00, 6'h00, 1'b1};
    tbl[10] = '{1'b0, 6'h3F, 10, 6'h00, 6'h00, 6'h30, 6'h00, 1'b0};
    tbl[11] = '{1'b0, 6'h3F, 2,  6'h00, 6'h00, 6'h00, 6'h00, 1'b0};

    for (int k = 0; k < 12; k++) begin
      rst  = tbl[k].rst;
      sw_n = tbl[k].sw_n;
      repeat (tbl[k].ncyc) tick();
      chk($sformatf("v%0d_level", k),   int'(key_level),   int'(tbl[k].lvl));
      chk($sformatf("v%0d_press", k),   int'(key_press),   int'(tbl[k].prs));
      chk($sformatf("v%0d_release", k), int'(key_release), int'(tbl[k].rel));
      chk($sformatf("v%0d_long", k),    int'(key_long),    int'(tbl[k].lng));
      chk($sformatf("v%0d_any", k),     int'(any_key),     int'(tbl[k].anyk));
    end

    // Bouncing key 1: 5 low / 3 high, four times, never long enough to register.
    clear_cnt();
    for (int b = 0; b < 4; b++) begin
      sw_n[1] = 1'b0; repeat (5) tick();
      sw_n[1] = 1'b1; repeat (3) tick();
    end
    repeat (12) tick();
    chk("bounce_level_seen", int'(level_seen[1]), 0);
    chk("bounce_press_cnt", press_cnt[1], 0);
    chk("bounce_release_cnt", release_cnt[1], 0);

    // Key 2 long press: held 60 cycles after press, then released.
    clear_cnt();
    sw_n[2] = 1'b0; c0 = cyc;
    repeat (10) tick();
    chk("long2_press_cyc", press_cyc[2], c0 + 10);
    repeat (60) tick();
    chk("long2_long_cnt", long_cnt[2], 1);
    chk("long2_long_cyc", long_cyc[2], press_cyc[2] + 40);
    sw_n[2] = 1'b1; r0 = cyc;
    repeat (12) tick();
    chk("long2_release_cyc", release_cyc[2], r0 + 10);
    repeat (50) tick();
    chk("long2_long_after_release", long_cnt[2], 1);

    // Key 3 released before the long threshold.
    clear_cnt();
    sw_n[3] = 1'b0;
    repeat (10) tick();
    chk("short3_press_cnt", press_cnt[3], 1);
    repeat (20) tick();
    sw_n[3] = 1'b1; r0 = cyc;
    repeat (60) tick();
    chk("short3_release_cyc", release_cyc[3], r0 + 10);
    chk("short3_release_cnt", release_cnt[3], 1);
    chk("short3_long_cnt", long_cnt[3], 0);

    // Key 0 held through a one-cycle reset at hold count 20.
    clear_cnt();
    sw_n[0] = 1'b0; c0 = cyc;
    repeat (10) tick();
    chk("rst0_press_cyc", press_cyc[0], c0 + 10);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("rst0_level", int'(key_level), 0);
    chk("rst0_press", int'(key_press), 0);
    chk("rst0_release", int'(key_release), 0);
    chk("rst0_long", int'(key_long), 0);
    chk("rst0_any", int'(any_key), 0);
    rst = 1'b0;
    clear_cnt();
    r0 = cyc;
    repeat (10) tick();
    chk("rst0_repress_cyc", press_cyc[0], r0 + 10);
    repeat (45) tick();
    chk("rst0_long_cnt", long_cnt[0], 1);
    chk("rst0_long_cyc", long_cyc[0], press_cyc[0] + 40);
    chk("rst0_release_cnt", release_cnt[0], 0);
    sw_n[0] = 1'b1;
    repeat (12) tick();
    chk("rst0_final_release", release_cnt[0], 1);

    chk("press_release_overlap", int'(both_seen), 0);
    chk("any_key_vs_level", int'(any_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 6: number of independent key channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 120900: stability window, 10 ms at 12.09 MHz; legal range >= 2.
REQ-003 Parameter LONG_CYCLES, default 12090000: long-press threshold, 1 s at 12.09 MHz; legal range > DEBOUNCE_CYCLES.
REQ-004 Port clk, input, 1: internal-oscillator clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous to clk, active-high.
REQ-006 Port sw_n, input, N_KEYS: raw key/button pins, asynchronous, active-low (0 = pressed).
REQ-007 Port key_level, output, N_KEYS: debounced state per key, 1 = pressed.
REQ-008 Port key_press, output, N_KEYS: one-cycle pulse per debounced press.
REQ-009 Port key_release, output, N_KEYS: one-cycle pulse per debounced release.
REQ-010 Port key_long, output, N_KEYS: one-cycle pulse per press held for LONG_CYCLES.
REQ-011 Port any_key, output, 1: OR of all key_level bits.

Function
REQ-012 Each sw_n bit SHALL pass through a 2-flop synchronizer and be inverted; the second flop output s[i] is the sampled pressed state.
REQ-013 Per key, a debounce counter (width clog2(DEBOUNCE_CYCLES)) SHALL clear whenever s[i] == key_level[i] and increment whenever they differ.
REQ-014 When they differ and the counter equals DEBOUNCE_CYCLES-1, key_level[i] SHALL take s[i] at that edge and the counter SHALL clear.
REQ-015 Latency: a raw level held stable SHALL update key_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling it.
REQ-016 Any return of s[i] to key_level[i] before the window completes (bounce) SHALL clear the counter; no output changes.
REQ-017 key_press[i] SHALL be 1 exactly in the cycle key_level[i] first reads 1; key_release[i] exactly in the cycle it first reads 0; both registered, never asserted together.
REQ-018 Per key, a hold counter (width clog2(LONG_CYCLES)+1) SHALL be 0 while key_level[i]=0 and increment each cycle while key_level[i]=1, saturating at LONG_CYCLES.
REQ-019 key_long[i] SHALL pulse for one cycle exactly LONG_CYCLES cycles after the key_press[i] cycle, at most once per press; release before then SHALL suppress it.
REQ-020 Keys SHALL be fully independent; simultaneous events on several keys SHALL produce simultaneous pulses with no arbitration or loss.
REQ-021 any_key SHALL be the combinational OR of registered key_level bits (no extra latency).

Reset
REQ-022 With rst=1 at a rising edge: synchronizer flops, key_level, key_press, key_release, key_long, all counters SHALL be 0; any_key therefore 0.
REQ-023 rst SHALL override all other activity, including a debounce window or hold count in progress; a key still held after rst falls SHALL be reported as a fresh press after DEBOUNCE_CYCLES+2 edges.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=40, N_KEYS=6)
REQ-024 sw_n[0] 1->0 held -> key_level[0]=1 and key_press[0] one-cycle pulse at edge 10; any_key=1 same cycle.
REQ-025 sw_n[1] bursts low for 5 cycles, high 3, repeated 4 times, then high -> key_level[1], key_press[1], key_release[1] stay 0 throughout.
REQ-026 sw_n[2] pressed, held 60 cycles after key_press -> key_long[2] single pulse 40 cycles after key_press; released -> key_release[2] 10 edges after raw release, no further key_long.
REQ-027 sw_n[3] pressed, released 20 cycles after key_press -> key_release[3] pulse, key_long[3] never asserted.
REQ-028 sw_n[4] and sw_n[5] fall on the same edge -> key_press[4] and key_press[5] pulse in the same cycle.
REQ-029 sw_n[0] held low, rst pulsed 1 cycle mid-hold at count 20 -> all outputs 0 next cycle; key_press[0] re-pulses 10 edges after rst deasserts; key_long[0] 40 cycles after that.
